// File: rtl/xor_key_lock_ctrl.sv
// rtl/xor_key_lock_ctrl.sv - serial key loader and valid/ready XOR wrapper for a key-locked core
// Optional build macro XOR_KEY_PARITY_EN appends an even-parity bit to the serial key.
module xor_key_lock_ctrl #(
    parameter int DATA_W    = 36,
    parameter int OUT_W     = 7,
    parameter int IN_KEY_W  = 22,
    parameter int OUT_KEY_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_sin,
    input  logic              key_shift,
    input  logic              key_commit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] core_in,
    input  logic [OUT_W-1:0]  core_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [1:0]        key_state,
    output logic              key_err
);

    localparam int KEY_W = IN_KEY_W + OUT_KEY_W;
`ifdef XOR_KEY_PARITY_EN
    localparam int SH_W  = KEY_W + 1;
`else
    localparam int SH_W  = KEY_W;
`endif
    localparam int CNT_W = $clog2(SH_W + 1);

    localparam logic [1:0] ST_LOCKED  = 2'd0;
    localparam logic [1:0] ST_LOADING = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_ARMED   = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [SH_W-1:0]   shadow_q,   shadow_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [KEY_W-1:0]  active_q,   active_d;
    logic              key_err_q,  key_err_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] core_in_q,  core_in_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;

    logic [SH_W-1:0]   shadow_shifted;
    logic [CNT_W-1:0]  cnt_sat;
    logic [KEY_W-1:0]  shadow_key;
    logic              parity_ok;
    logic              count_full;
    logic              pipe_empty;
    logic              s1_adv;
    logic              accept;
    logic [DATA_W-1:0] in_key_ext;
    logic [OUT_W-1:0]  out_key_ext;

`ifdef XOR_KEY_PARITY_EN
    // shadow[0] is the last bit shifted and carries even parity over the key bits above it
    assign shadow_key = shadow_q[KEY_W:1];
    assign parity_ok  = ~(^shadow_q);
`else
    assign shadow_key = shadow_q[KEY_W-1:0];
    assign parity_ok  = 1'b1;
`endif

    assign shadow_shifted = {shadow_q[SH_W-2:0], key_sin};
    assign count_full     = (cnt_q == CNT_W'(SH_W));
    assign cnt_sat        = count_full ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        in_key_ext                 = '0;
        in_key_ext[IN_KEY_W-1:0]   = active_q[IN_KEY_W-1:0];
        out_key_ext                = '0;
        out_key_ext[OUT_KEY_W-1:0] = active_q[KEY_W-1:IN_KEY_W];
    end

    assign pipe_empty = !s1_valid_q && !out_valid_q;
    assign s1_adv     = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready   = (state_q == ST_ARMED) && (!s1_valid_q || s1_adv);
    assign accept     = in_valid && in_ready;

    // Key FSM; the active key only moves while the pipeline is empty so in-flight beats keep their key
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        key_err_d = key_err_q;
        case (state_q)
            ST_LOCKED: begin
                if (key_shift) begin
                    state_d   = ST_LOADING;
                    key_err_d = 1'b0;
                    shadow_d  = shadow_shifted;
                    cnt_d     = CNT_W'(1);
                end
            end
            ST_LOADING: begin
                if (key_commit) begin
                    state_d = ST_DRAIN;
                end else if (key_shift) begin
                    shadow_d = shadow_shifted;
                    cnt_d    = cnt_sat;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    if (count_full && parity_ok) begin
                        active_d = shadow_key;
                        state_d  = ST_ARMED;
                    end else begin
                        key_err_d = 1'b1;
                        state_d   = ST_LOCKED;
                        shadow_d  = '0;
                        cnt_d     = '0;
                    end
                end
            end
            ST_ARMED: begin
                if (key_shift) begin
                    state_d  = ST_LOADING;
                    shadow_d = shadow_shifted;
                    cnt_d    = CNT_W'(1);
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        core_in_d   = core_in_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            core_in_d  = in_data ^ in_key_ext;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = core_out ^ out_key_ext;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOCKED;
            shadow_q    <= '0;
            cnt_q       <= '0;
            active_q    <= '0;
            key_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            core_in_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            key_err_q   <= key_err_d;
            s1_valid_q  <= s1_valid_d;
            core_in_q   <= core_in_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign core_in   = core_in_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign key_state = state_q;
    assign key_err   = key_err_q;

endmodule

// File: tb/tb_xor_key_lock_ctrl.sv
// tb/tb_xor_key_lock_ctrl.sv - randomized bench for xor_key_lock_ctrl against a behavioural model
module tb_xor_key_lock_ctrl;

    localparam int DATA_W    = 36;
    localparam int OUT_W     = 7;
    localparam int IN_KEY_W  = 22;
    localparam int OUT_KEY_W = 4;
    localparam int KEY_W     = IN_KEY_W + OUT_KEY_W;
`ifdef XOR_KEY_PARITY_EN
    localparam int SH_W = KEY_W + 1;
`else
    localparam int SH_W = KEY_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_sin = 1'b0;
    logic              key_shift = 1'b0;
    logic              key_commit = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] core_in;
    logic [OUT_W-1:0]  core_out;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic [1:0]        key_state;
    logic              key_err;
    logic              core_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    xor_key_lock_ctrl #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .IN_KEY_W(IN_KEY_W), .OUT_KEY_W(OUT_KEY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_sin(key_sin), .key_shift(key_shift),
        .key_commit(key_commit), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .core_in(core_in), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_state(key_state), .key_err(key_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational core
    function automatic logic [OUT_W-1:0] core_fn(input logic mode, input logic [DATA_W-1:0] x);
        if (!mode) return '0;
        return x[6:0] ^ x[35:29] ^ x[20:14];
    endfunction

    assign core_out = core_fn(core_mode, core_in);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: key as a list of shifted bits, pipeline as two slots of expected values
    int                m_state;
    bit                m_bits[$];
    int                m_cnt;
    logic [KEY_W-1:0]  m_key;
    bit                m_err;
    bit                m_s1v, m_s2v;
    logic [DATA_W-1:0] m_core_in;
    logic [OUT_W-1:0]  m_out;
    bit                exp_rdy;

    task automatic model_reset();
        m_state = 0; m_bits.delete(); m_cnt = 0; m_key = '0; m_err = 0;
        m_s1v = 0; m_s2v = 0; m_core_in = '0; m_out = '0;
    endtask

    function automatic logic [SH_W-1:0] window();
        logic [SH_W-1:0] sv = '0;
        foreach (m_bits[i]) sv = {sv[SH_W-2:0], m_bits[i]};
        return sv;
    endfunction

    task automatic push_bit(input bit b);
        m_bits.push_back(b);
        if (m_bits.size() > SH_W) void'(m_bits.pop_front());
    endtask

    task automatic model_step();
        bit empty, adv, acc;
        logic [SH_W-1:0] sv;
        logic [DATA_W-1:0] ikey;
        logic [OUT_W-1:0] okey;
        ikey  = DATA_W'(m_key) & ((DATA_W'(1) << IN_KEY_W) - DATA_W'(1));
        okey  = OUT_W'(m_key >> IN_KEY_W);
        empty = !m_s1v && !m_s2v;
        adv   = m_s1v && (!m_s2v || out_ready);
        exp_rdy = (m_state == 3) && (!m_s1v || adv);
        acc   = in_valid && exp_rdy;
        if (adv) begin
            m_s2v = 1;
            m_out = core_fn(core_mode, m_core_in) ^ okey;
        end else if (out_ready) begin
            m_s2v = 0;
        end
        if (acc) begin
            m_s1v = 1;
            m_core_in = in_data ^ ikey;
        end else if (adv) begin
            m_s1v = 0;
        end
        case (m_state)
            0: if (key_shift) begin push_bit(key_sin); m_cnt = 1; m_err = 0; m_state = 1; end
            1: if (key_commit) m_state = 2;
               else if (key_shift) begin push_bit(key_sin); if (m_cnt < SH_W) m_cnt++; end
            2: if (empty) begin
                   sv = window();
                   if (m_cnt == SH_W && ($countones(sv) % 2 == 0 || SH_W == KEY_W)) begin
                       m_key = KEY_W'(sv >> (SH_W - KEY_W));
                       m_state = 3;
                   end else begin
                       m_err = 1; m_state = 0; m_bits.delete(); m_cnt = 0;
                   end
               end
            default: if (key_shift) begin push_bit(key_sin); m_cnt = 1; m_state = 1; end
        endcase
    endtask

    task automatic step();
        #2;
        model_step();
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        check("key_state", 64'(key_state), 64'(m_state));
        check("key_err", 64'(key_err), 64'(m_err));
        check("out_valid", 64'(out_valid), 64'(m_s2v));
        check("out_data", 64'(out_data), 64'(m_out));
        check("core_in", 64'(core_in), 64'(m_core_in));
    endtask

    function automatic logic [SH_W-1:0] mk_sh(input logic [KEY_W-1:0] k, input bit bad);
`ifdef XOR_KEY_PARITY_EN
        return {k, (^k) ^ bad};
`else
        return SH_W'(k) ^ SH_W'(bad);
`endif
    endfunction

    task automatic load_bits(input logic [SH_W-1:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            key_shift = 1'b1;
            key_sin   = v[i];
            step();
        end
        key_shift = 1'b0;
    endtask

    task automatic commit_and_drain();
        key_commit = 1'b1;
        step();
        key_commit = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 20 && m_state == 2; i++) step();
        check("drain_done", 64'(key_state != 2'd2), 64'd1);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_state", 64'(key_state), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_core_in", 64'(core_in), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic random_traffic(input int n, input bit key_ops);
        for (int i = 0; i < n; i++) begin
            in_valid   = ($urandom_range(0, 2) != 0);
            in_data    = {$urandom(), $urandom()};
            out_ready  = ($urandom_range(0, 3) != 0);
            key_shift  = key_ops && ($urandom_range(0, 7) == 0);
            key_sin    = $urandom_range(0, 1);
            key_commit = key_ops && ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid = 1'b0; key_shift = 1'b0; key_commit = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        model_reset();
        in_valid = 1'b1;
        #12;
        check("reset_state", 64'(key_state), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_core_in", 64'(core_in), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;

        // All-ones key, zero core: fixed expected latency and values
        load_bits(mk_sh('1, 1'b0), SH_W);
        commit_and_drain();
        check("ones_armed", 64'(key_state), 64'd3);
        in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_core_in", 64'(core_in), 64'h0003FFFFF);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        step();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_data", 64'(out_data), 64'h0F);
        step();

        // Short key -> error, next shift clears it
        load_bits(SH_W'({$urandom(), $urandom()}), SH_W - 2);
        commit_and_drain();
        check("short_err", 64'(key_err), 64'd1);
        check("short_locked", 64'(key_state), 64'd0);
        key_shift = 1'b1; key_sin = 1'b1;
        step();
        key_shift = 1'b0;
        check("err_cleared", 64'(key_err), 64'd0);
        check("err_loading", 64'(key_state), 64'd1);
        k = KEY_W'({$urandom(), $urandom()});
        load_bits(mk_sh(k, 1'b0), SH_W);
        commit_and_drain();
        core_mode = 1'b1;
        random_traffic(150, 1'b0);

        // Backpressure: three offered beats, two accepted, output held
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = {$urandom(), $urandom()};
            step();
        end
        check("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Rekey with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = {$urandom(), $urandom()};
            step();
        end
        in_valid = 1'b0;
        k = KEY_W'({$urandom(), $urandom()});
        key_shift = 1'b1; key_sin = 1'b0;
        step();
        key_shift = 1'b0;
        check("rekey_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        load_bits(mk_sh(k, 1'b0), SH_W);
        commit_and_drain();
        random_traffic(100, 1'b0);

        // Reset during loading, then full reload
        load_bits(SH_W'({$urandom(), $urandom()}), 10);
        pulse_reset();
        check("rst_locked", 64'(key_state), 64'd0);
        k = KEY_W'({$urandom(), $urandom()});
        load_bits(mk_sh(k, 1'b0), SH_W);
        commit_and_drain();
        check("reload_armed", 64'(key_state), 64'd3);
        random_traffic(150, 1'b0);

`ifdef XOR_KEY_PARITY_EN
        load_bits(mk_sh(k, 1'b1), SH_W);
        commit_and_drain();
        check("parity_bad_err", 64'(key_err), 64'd1);
        load_bits(mk_sh(k, 1'b0), SH_W);
        commit_and_drain();
        check("parity_good_armed", 64'(key_state), 64'd3);
`endif

        random_traffic(400, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
